cipher_code_entry: RTL and testbench



---
 rtl/cipher_pkg.sv | 19 +
 rtl/debounce_pulse.sv | 40 ++++
 rtl/cipher_code_entry.sv | 113 +++++++++++
 tb/tb_cipher_code_entry.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher code entry and display-side select logic.
package cipher_pkg;

    localparam int unsigned DIG_W     = 4;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned NUM_CODES = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_O_W   = 3;

    localparam logic [15:0] CODE_WORDS [4] = '{16'h3245, 16'h3607, 16'h5408, 16'h0388};

    typedef enum logic [1:0] {COLLECT, LOOKUP, DONE} entry_state_t;

    typedef struct packed {
        logic             match;
        logic [IDX_W-1:0] idx;
    } lookup_result_t;

endpackage

// File: rtl/debounce_pulse.sv
// Synchronizes a raw button, debounces it with a saturating counter and emits one pulse per push.
module debounce_pulse #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned    CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    // Saturation at CNT_MAX blocks a second pulse until the level drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pulse <= r_sync2 && (r_cnt == (CNT_MAX - CNT_W'(1)));
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/cipher_code_entry.sv
// Collects four debounced hex digits and decodes them to a codeword selection index.
module cipher_code_entry
    import cipher_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   din,
    input  logic         enter,
    input  logic         clr,
    output logic [15:0]  dig,
    output logic [2:0]   cnt,
    output logic         valid,
    output logic         match,
    output logic [1:0]   idx
);

    logic                w_press;
    entry_state_t        r_state, w_state_nxt;
    logic [WORD_W-1:0]   r_dig, w_dig_nxt;
    logic [CNT_O_W-1:0]  r_cnt, w_cnt_nxt;
    logic                r_valid, w_valid_nxt;
    lookup_result_t      r_res, w_res_nxt;
    lookup_result_t      w_hit;

    debounce_pulse #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (enter),
        .pulse (w_press)
    );

    // Table compare; idx stays 0 when nothing matches.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < int'(NUM_CODES); i++) begin
            if (r_dig == CODE_WORDS[i]) begin
                w_hit.match = 1'b1;
                w_hit.idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dig_nxt   = r_dig;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_res_nxt   = r_res;
        if (clr) begin
            w_state_nxt = COLLECT;
            w_dig_nxt   = '0;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_res_nxt   = '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_press) begin
                        w_dig_nxt = {r_dig[WORD_W-DIG_W-1:0], din};
                        w_cnt_nxt = r_cnt + CNT_O_W'(1);
                        if (r_cnt == CNT_O_W'(3)) begin
                            w_state_nxt = LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    w_res_nxt   = w_hit;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = DONE;
                end
                DONE: begin
                    if (w_press) begin
                        w_dig_nxt   = {12'h000, din};
                        w_cnt_nxt   = CNT_O_W'(1);
                        w_valid_nxt = 1'b0;
                        w_res_nxt   = '0;
                        w_state_nxt = COLLECT;
                    end
                end
                default: begin
                    w_state_nxt = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= COLLECT;
            r_dig   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dig   <= w_dig_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_res   <= w_res_nxt;
        end
    end

    assign dig   = r_dig;
    assign cnt   = r_cnt;
    assign valid = r_valid;
    assign match = r_res.match;
    assign idx   = r_res.idx;

endmodule

// File: tb/tb_cipher_code_entry.sv
// Self-checking bench for cipher_code_entry: vector table, corner sequences and random pushes vs a model.
module tb_cipher_code_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  din;
    logic        enter;
    logic        clr;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic        valid;
    logic        match;
    logic [1:0]  idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the user has keyed in and what the spec says it decodes to.
    logic [15:0] m_dig;
    int          m_cnt;
    bit          m_valid;
    bit          m_match;
    int          m_idx;
    logic [15:0] ref_codes [4] = '{16'h3245, 16'h3607, 16'h5408, 16'h0388};

    typedef struct {
        logic [15:0] word;
        bit          exp_match;
        int          exp_idx;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    cipher_code_entry #(.DB_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .enter (enter),
        .clr   (clr),
        .dig   (dig),
        .cnt   (cnt),
        .valid (valid),
        .match (match),
        .idx   (idx)
    );

    task automatic model_clear();
        m_dig = 16'h0; m_cnt = 0; m_valid = 0; m_match = 0; m_idx = 0;
    endtask

    task automatic model_press(input logic [3:0] d);
        if (m_cnt == 4) begin
            model_clear();
            m_dig = {12'h000, d};
            m_cnt = 1;
        end else begin
            m_dig = {m_dig[11:0], d};
            m_cnt = m_cnt + 1;
            if (m_cnt == 4) begin
                m_valid = 1;
                m_match = 0;
                m_idx   = 0;
                foreach (ref_codes[k]) begin
                    if (ref_codes[k] == m_dig) begin
                        m_match = 1;
                        m_idx   = k;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " dig"},   int'(dig),   int'(m_dig));
        chk({tag, " cnt"},   int'(cnt),   m_cnt);
        chk({tag, " valid"}, int'(valid), int'(m_valid));
        chk({tag, " match"}, int'(match), int'(m_match));
        chk({tag, " idx"},   int'(idx),   m_idx);
    endtask

    task automatic push(input logic [3:0] d);
        @(negedge clk);
        din   = d;
        enter = 1'b1;
        repeat (8) @(negedge clk);
        enter = 1'b0;
        repeat (8) @(negedge clk);
        model_press(d);
    endtask

    task automatic bounce_push(input logic [3:0] d);
        @(negedge clk); din = d; enter = 1'b1;
        @(negedge clk); enter = 1'b0;
        @(negedge clk); enter = 1'b1;
        @(negedge clk); enter = 1'b0;
        push(d);
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int k = 0; k < 4; k++) begin
            push(w[15-4*k -: 4]);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [15:0] w;
        reset = 1'b0; din = 4'h0; enter = 1'b0; clr = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk_all("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Short push below the debounce threshold is not a press.
        din = 4'h9; enter = 1'b1;
        repeat (3) @(negedge clk);
        enter = 1'b0;
        repeat (8) @(negedge clk);
        chk_all("short");

        vecs[0] = '{16'h3245, 1'b1, 0};
        vecs[1] = '{16'h0388, 1'b1, 3};
        vecs[2] = '{16'h0389, 1'b0, 0};
        vecs[3] = '{16'h3607, 1'b1, 1};
        vecs[4] = '{16'h5408, 1'b1, 2};
        vecs[5] = '{16'hFFFF, 1'b0, 0};
        foreach (vecs[v]) begin
            push_word(vecs[v].word);
            chk("vec dig",   int'(dig),   int'(vecs[v].word));
            chk("vec cnt",   int'(cnt),   4);
            chk("vec valid", int'(valid), 1);
            chk("vec match", int'(match), int'(vecs[v].exp_match));
            chk("vec idx",   int'(idx),   vecs[v].exp_idx);
            chk_all("vec model");
        end

        // Lookup latency: press lands 7 edges after enter rises, valid one edge later.
        pulse_clr();
        push(4'h3); push(4'h6); push(4'h0);
        @(negedge clk); din = 4'h7; enter = 1'b1;
        repeat (6) @(negedge clk);
        chk("lat pre cnt", int'(cnt), 3);
        @(negedge clk);
        chk("lat press cnt",   int'(cnt),   4);
        chk("lat press dig",   int'(dig),   16'h3607);
        chk("lat press valid", int'(valid), 0);
        @(negedge clk);
        chk("lat valid", int'(valid), 1);
        chk("lat match", int'(match), 1);
        chk("lat idx",   int'(idx),   1);
        enter = 1'b0;
        repeat (8) @(negedge clk);
        model_press(4'h7);
        chk_all("lat");

        // Bouncy push counts once.
        pulse_clr();
        push(4'h1);
        bounce_push(4'h5);
        chk_all("bounce");

        // New press from DONE restarts entry, then clr wins over a coincident press.
        pulse_clr();
        push_word(16'h5408);
        chk_all("done5408");
        push(4'h7);
        chk_all("restart");
        @(negedge clk); din = 4'hD; enter = 1'b1;
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        chk_all("clr+press");
        enter = 1'b0;
        repeat (8) @(negedge clk);
        chk_all("clr+press after");
        push_word(16'h0388);
        chk_all("after clr");

        // Asynchronous reset mid-entry.
        pulse_clr();
        push(4'h3); push(4'h6);
        chk_all("two digits");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk_all("async reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_all("post reset");

        // Randomized entry against the model.
        for (int g = 0; g < 15; g++) begin
            w = ($urandom_range(1, 0) == 1) ? ref_codes[$urandom_range(3, 0)] : 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(9, 0) == 0) begin
                    pulse_clr();
                    chk_all("rand clr");
                end
                if ($urandom_range(3, 0) == 0) begin
                    bounce_push(w[15-4*k -: 4]);
                end else begin
                    push(w[15-4*k -: 4]);
                end
                chk_all("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
